// File: rtl/mem_bus_pkg.sv
// Shared I/O map constants for the CPU memory/I/O responder.
package mem_bus_pkg;

    localparam logic [17:0] IO_BASE   = 18'h30000;
    localparam logic [17:0] IO_CLK    = 18'h30004;
    localparam logic [1:0]  IO_REGION = 2'b11;

    function automatic logic is_io_region(input logic [1:0] region);
        return region == IO_REGION;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, 2**DEPTH_BIT entries, head visible on dout_o; occupancy carries one extra bit.
module byte_fifo #(
    parameter int DEPTH_BIT = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               push_i,
    input  logic [7:0]         din_i,
    input  logic               pop_i,
    output logic [7:0]         dout_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [DEPTH_BIT:0] count_o
);

    localparam int DEPTH = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0]   FULL_CNT = (DEPTH_BIT + 1)'(DEPTH);
    localparam logic [DEPTH_BIT:0]   CNT_ONE  = (DEPTH_BIT + 1)'(1);
    localparam logic [DEPTH_BIT-1:0] PTR_ONE  = DEPTH_BIT'(1);

    logic [7:0]           buf_q [DEPTH];
    logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BIT:0]   cnt_q, cnt_d;
    logic                 do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign dout_o  = buf_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (do_push) buf_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// CPU bus responder: byte RAM plus UART TX/RX FIFOs, cycle counter and stop flag.
// Define MEM_BUS_RX_EN to build the RX FIFO; otherwise rx_* is ignored and 0x30000 reads 0.
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int RAM_ADDR_BIT   = 17,
    parameter int FIFO_DEPTH_BIT = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] bus_a,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr,
    output logic [7:0]  bus_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_stop
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BIT;
    localparam int CW    = FIFO_DEPTH_BIT + 1;
    localparam logic [CW-1:0] ALMOST_FULL = CW'(DEPTH - 1);

    logic [7:0]              mem [0:(1 << RAM_ADDR_BIT) - 1];
    logic [RAM_ADDR_BIT-1:0] ram_addr;
    logic [17:0]             io_addr;
    logic                    io_sel, rd_io, wr_io;

    assign ram_addr = bus_a[RAM_ADDR_BIT-1:0];
    assign io_addr  = bus_a[17:0];
    assign io_sel   = is_io_region(bus_a[17:16]);
    assign rd_io    = io_sel && !bus_wr;
    assign wr_io    = io_sel && bus_wr;

    logic          tx_push, tx_pop, tx_empty, unused_tx_full;
    logic [7:0]    tx_din;
    logic [CW-1:0] tx_count;

    // A stop write queues a 0x00 marker so the host sees end-of-program in-band.
    assign tx_push = wr_io && ((io_addr == IO_BASE && bus_wdata != 8'h00) || io_addr == IO_CLK);
    assign tx_din  = (io_addr == IO_CLK) ? 8'h00 : bus_wdata;
    assign tx_pop  = tx_valid && tx_ready;

    byte_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT)) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (tx_push),
        .din_i   (tx_din),
        .pop_i   (tx_pop),
        .dout_o  (tx_data),
        .full_o  (unused_tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    assign tx_valid       = !tx_empty;
    assign io_buffer_full = (tx_count >= ALMOST_FULL);

    logic       rx_pop, rx_empty;
    logic [7:0] rx_head;

    assign rx_pop = rd_io && (io_addr == IO_BASE) && !rx_empty;

`ifdef MEM_BUS_RX_EN
    logic          unused_rx_full;
    logic [CW-1:0] unused_rx_cnt;

    byte_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT)) u_rx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (rx_valid),
        .din_i   (rx_data),
        .pop_i   (rx_pop),
        .dout_o  (rx_head),
        .full_o  (unused_rx_full),
        .empty_o (rx_empty),
        .count_o (unused_rx_cnt)
    );
`else
    logic unused_rx;
    assign rx_head   = 8'h00;
    assign rx_empty  = 1'b1;
    assign unused_rx = ^{rx_data, rx_valid, rx_pop};
`endif

    logic        unused_hi;
    assign unused_hi = ^bus_a[31:18];

    logic [31:0] cnt_q, cnt_d, snap_q, snap_d;
    logic [7:0]  io_q, io_d, ram_q;
    logic        sel_ram_q, sel_ram_d, stop_q, stop_d;

    always_comb begin
        cnt_d     = cnt_q + 32'd1;
        snap_d    = snap_q;
        io_d      = 8'h00;
        sel_ram_d = !io_sel;
        stop_d    = stop_q || (wr_io && io_addr == IO_CLK);
        if (rd_io) begin
            // Only the low byte re-latches, so a 4-byte read sequence stays coherent.
            case (io_addr)
                IO_BASE:         io_d = rx_empty ? 8'h00 : rx_head;
                IO_CLK: begin
                    io_d   = cnt_q[7:0];
                    snap_d = cnt_q;
                end
                IO_CLK + 18'd1:  io_d = snap_q[15:8];
                IO_CLK + 18'd2:  io_d = snap_q[23:16];
                IO_CLK + 18'd3:  io_d = snap_q[31:24];
                default:         io_d = 8'h00;
            endcase
        end
    end

    // RAM kept reset-free so it maps onto block memory.
    always_ff @(posedge clk_in) begin
        if (bus_wr && !io_sel) mem[ram_addr] <= bus_wdata;
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q     <= '0;
            snap_q    <= '0;
            io_q      <= '0;
            sel_ram_q <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            io_q      <= io_d;
            sel_ram_q <= sel_ram_d;
            stop_q    <= stop_d;
        end
    end

    assign bus_rdata    = sel_ram_q ? ram_q : io_q;
    assign program_stop = stop_q;

endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 The module SHALL take parameter RAM_ADDR_BIT, default 17, which sets the RAM byte-address width (128 KB).
REQ-002 The module SHALL take parameter FIFO_DEPTH_BIT, default 3, which sets the TX and RX FIFO depth to 2**FIFO_DEPTH_BIT entries.
REQ-003 clk_in  in  1  single clock.
REQ-004 rst_in  in  1  reset, synchronous, active-high.
REQ-005 bus_a  in  32  byte address from the CPU; only bits 17:0 decoded.
REQ-006 bus_wdata  in  8  CPU write data.
REQ-007 bus_wr  in  1  1 = write, 0 = read.
REQ-008 bus_rdata  out  8  read data, registered.
REQ-009 io_buffer_full  out  1  TX FIFO almost-full flag.
REQ-010 tx_data  out  8  UART TX byte.
REQ-011 tx_valid  out  1  TX byte available.
REQ-012 tx_ready  in  1  UART accepts the byte.
REQ-013 rx_data  in  8  UART RX byte.
REQ-014 rx_valid  in  1  RX byte offered.
REQ-015 program_stop  out  1  sticky flag: program has ended.

Function
REQ-016 A bus access SHALL target RAM when bus_a[17:16] != 2'b11, and SHALL target I/O otherwise.
REQ-017 A RAM read SHALL present mem[bus_a[RAM_ADDR_BIT-1:0]] on bus_rdata exactly one cycle after the address, every cycle with no handshake.
REQ-018 A RAM write SHALL complete in its cycle, and a read of the same address in the next cycle SHALL return the new data.
REQ-019 A write to 0x30000 with nonzero data SHALL push the data into the TX FIFO; a write with 0x00 SHALL be ignored.
REQ-020 A write to 0x30004 SHALL set program_stop (sticky until reset) and SHALL push 0x00 into the TX FIFO.
REQ-021 A TX push while the FIFO is full and not popping SHALL be dropped with no state change; a push and pop in the same cycle on a full FIFO SHALL both occur.
REQ-022 io_buffer_full SHALL be 1 when TX occupancy >= depth-1, which gives one cycle of slack for CPU latency.
REQ-023 tx_valid SHALL equal TX-not-empty and tx_data SHALL equal the TX head; the FIFO SHALL pop when tx_valid && tx_ready.
REQ-024 rx_valid SHALL push rx_data into the RX FIFO; a push when the FIFO is full SHALL be dropped.
REQ-025 A read of 0x30000 SHALL return the RX head next cycle and pop it; a read of an empty RX FIFO SHALL return 0x00 with no pop.
REQ-026 The cycle counter SHALL be 32 bits, start at 0 after reset, increment every cycle, and wrap at 2**32.
REQ-027 A read of 0x30004 SHALL latch a counter snapshot and return snapshot[7:0].
REQ-028 Reads of 0x30005, 0x30006 and 0x30007 SHALL return snapshot bytes 1, 2 and 3, with no re-latch.
REQ-029 Other I/O addresses SHALL read 0x00 and ignore writes.
REQ-030 FIFO pointers SHALL wrap modulo depth, and occupancy SHALL be tracked with one extra bit.

Reset
REQ-031 On rst_in, bus_rdata SHALL become 0, both FIFOs SHALL empty, tx_valid SHALL become 0, io_buffer_full SHALL become 0, program_stop SHALL become 0, and the counter and snapshot SHALL become 0.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 Reset asserted mid-operation SHALL discard any pending TX/RX bytes.

Configuration
REQ-034 When MEM_BUS_RX_EN is defined, the RX FIFO and rx_* ports SHALL be functional.
REQ-035 When MEM_BUS_RX_EN is not defined, no RX FIFO SHALL be built, rx_valid SHALL be ignored, and reads of 0x30000 SHALL return 0x00.

Structure
REQ-036 Package mem_bus_pkg SHALL hold the IO_BASE (0x30000) and IO_CLK (0x30004) constants and the IO region code 2'b11.
REQ-037 A sub-module byte_fifo (parameterised depth, push/pop/full/empty/count) SHALL be instantiated for TX, and for RX when it is enabled.

Verification
REQ-038 Write 0xA5 to 0x00010, then read 0x00010 -> bus_rdata = 0xA5 on the next cycle.
REQ-039 With tx_ready=0, write 'H', 0x00, 'i' to 0x30000 -> TX occupancy = 2; after setting tx_ready=1, tx_data sequence is 0x48 then 0x69.
REQ-040 With tx_ready=0, write 7 nonzero bytes (depth 8) -> io_buffer_full = 1; the 9th write is dropped.
REQ-041 After 100 cycles past reset, read 0x30004..0x30007 -> the four bytes form a value of 100 or more, and the snapshot stays coherent across all four reads.
REQ-042 Write 0x30004 -> program_stop = 1, and a 0x00 byte appears on tx_data.
REQ-043 Push rx 0x31 and 0x32, then read 0x30000 three times -> 0x31, 0x32, 0x00 (with MEM_BUS_RX_EN).
